// File: rtl/execute_jump_queue.sv
// execute_jump_queue
// Small in-order FIFO between execute and the fetch redirect logic. It keeps
// only branch / system-register-write results, decodes each into a jump
// record (redirect flag, target, kind) and presents the oldest record to the
// consumer. After a redirect is queued, the optional squash state drops the
// wrong-path entries that follow it until that redirect has been consumed.
module execute_jump_queue #(
  parameter int P_ADDR_W   = 32,
  parameter int P_DEPTH    = 4,
  parameter int P_SYSREG_N = 3,
  parameter int P_SQUASH   = 1
) (
  input  logic                             iCLOCK,
  input  logic                             inRESET,
  input  logic                             iRESET_SYNC,
  input  logic                             iEVENT_HOLD,
  input  logic                             iEVENT_END,
  input  logic                             iSTATE_NORMAL,
  input  logic                             iPREV_VALID,
  input  logic                             iPREV_EX_BRANCH,
  input  logic                             iPREV_EX_SYS_REG,
  input  logic [P_ADDR_W-1:0]              iPREV_PC,
  input  logic                             iPREV_PREDICT_ENA,
  input  logic                             iPREV_PREDICT_HIT,
  input  logic                             iPREV_PREDICT_MISS_VALID,
  input  logic                             iPREV_ADDR_MISS_VALID,
  input  logic                             iPREV_IB_VALID,
  input  logic [P_ADDR_W-1:0]              iPREV_BRANCH_ADDR,
  input  logic [P_SYSREG_N-1:0]            iPREV_SYSREG_VALID,
  input  logic [P_ADDR_W-1:0]              iPREV_SYSREG_ADDR,
  output logic                             oPREV_BUSY,
  input  logic                             iNEXT_BUSY,
  output logic                             oNEXT_VALID,
  output logic                             oNEXT_PREDICT_ENA,
  output logic                             oNEXT_PREDICT_HIT,
  output logic                             oNEXT_JUMP_VALID,
  output logic [P_ADDR_W-1:0]              oNEXT_JUMP_ADDR,
  output logic                             oNEXT_TYPE_BRANCH_VALID,
  output logic                             oNEXT_TYPE_BRANCH_IB_VALID,
  output logic [P_SYSREG_N-1:0]            oNEXT_TYPE_SYSREG_VALID,
  output logic                             oSQUASH,
  output logic [$clog2(P_DEPTH+1)-1:0]     oCOUNT
);

  localparam int LP_PTR_W = $clog2(P_DEPTH);
  localparam int LP_CNT_W = $clog2(P_DEPTH + 1);

  localparam logic [0:0] LP_IDLE   = 1'b0;
  localparam logic [0:0] LP_SQUASH = 1'b1;

  // One decoded queue record.
  typedef struct packed {
    logic                  predict_ena;
    logic                  predict_hit;
    logic                  jump;
    logic                  ib;
    logic [P_SYSREG_N-1:0] sysreg;
    logic [P_ADDR_W-1:0]   addr;
  } entry_t;

  entry_t              r_mem [P_DEPTH];
  logic [LP_PTR_W-1:0] r_wr_ptr;
  logic [LP_PTR_W-1:0] r_rd_ptr;
  logic [LP_CNT_W-1:0] r_count;
  logic [0:0]          r_state;

  logic [0:0] w_state_next;
  entry_t     w_entry;
  entry_t     w_head;
  logic       w_clear;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_redirect_in;

  assign w_clear = iRESET_SYNC || iEVENT_HOLD || iEVENT_END;
  assign w_full  = (r_count == LP_CNT_W'(P_DEPTH));
  assign w_empty = (r_count == '0);

  // Only branch/sysreg results are kept, and nothing while squashing.
  assign w_push = iSTATE_NORMAL && iPREV_VALID &&
                  (iPREV_EX_BRANCH || iPREV_EX_SYS_REG) &&
                  !w_full && (r_state == LP_IDLE);
  assign w_pop  = !w_empty && !iNEXT_BUSY;

  assign w_redirect_in = w_entry.jump || w_entry.ib || (|w_entry.sysreg);

  // Decode the upstream result into a queue record and select its target.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_entry             = '0;
    w_entry.jump        = iPREV_EX_BRANCH &&
                          (iPREV_PREDICT_MISS_VALID || iPREV_ADDR_MISS_VALID);
    w_entry.ib          = iPREV_EX_BRANCH && iPREV_IB_VALID;
    w_entry.sysreg      = iPREV_EX_SYS_REG ? iPREV_SYSREG_VALID : '0;
    w_entry.predict_ena = iPREV_EX_BRANCH ? iPREV_PREDICT_ENA : 1'b0;
    w_entry.predict_hit = iPREV_EX_BRANCH ? iPREV_PREDICT_HIT : 1'b0;
    if (iPREV_EX_BRANCH && (iPREV_ADDR_MISS_VALID || iPREV_IB_VALID)) begin
      w_entry.addr = iPREV_BRANCH_ADDR;
    end else if (iPREV_EX_BRANCH && iPREV_PREDICT_MISS_VALID) begin
      w_entry.addr = iPREV_PC;
    end else if (|w_entry.sysreg) begin
      w_entry.addr = iPREV_SYSREG_ADDR;
    end
  end

  // Squash FSM: enter on queuing a redirect, leave when that redirect
  // (necessarily the youngest and therefore last entry) is dequeued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LP_IDLE: begin
        if (w_push && w_redirect_in && (P_SQUASH != 0)) begin
          w_state_next = LP_SQUASH;
        end
      end
      LP_SQUASH: begin
        if (w_pop && (r_count == LP_CNT_W'(1))) begin
          w_state_next = LP_IDLE;
        end
      end
      default: w_state_next = LP_IDLE;
    endcase
  end

  // Pointers, occupancy and FSM state; a synchronous clear wins over push/pop.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= LP_IDLE;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= LP_IDLE;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LP_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - LP_CNT_W'(1);
      end
      r_state <= w_state_next;
    end
  end

  // Record storage, written at the tail on every accepted entry.
  // NOTE: the storage array has no reset; stale contents are never visible
  // because every output is masked while the queue is empty.
  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign oNEXT_VALID                = !w_empty;
  assign oNEXT_PREDICT_ENA          = w_head.predict_ena;
  assign oNEXT_PREDICT_HIT          = w_head.predict_hit;
  assign oNEXT_JUMP_VALID           = w_head.jump;
  assign oNEXT_JUMP_ADDR            = w_head.addr;
  assign oNEXT_TYPE_BRANCH_VALID    = w_head.jump && !w_head.ib;
  assign oNEXT_TYPE_BRANCH_IB_VALID = w_head.ib;
  assign oNEXT_TYPE_SYSREG_VALID    = w_head.sysreg;
  assign oSQUASH                    = (r_state == LP_SQUASH);
  // While squashing, report not-busy so upstream drains into the discard.
  assign oPREV_BUSY                 = w_full && (r_state == LP_IDLE);
  assign oCOUNT                     = r_count;

endmodule

// File: tb/tb_execute_jump_queue.sv
// Directed bench for execute_jump_queue: a vector table for single-cycle
// behaviour plus hand-written fill, squash and async-reset sequences. A second
// instance built with squashing disabled shares the same stimulus.
module tb_execute_jump_queue;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC, iEVENT_HOLD, iEVENT_END, iSTATE_NORMAL;
  logic        iPREV_VALID, iPREV_EX_BRANCH, iPREV_EX_SYS_REG;
  logic [31:0] iPREV_PC, iPREV_BRANCH_ADDR, iPREV_SYSREG_ADDR;
  logic        iPREV_PREDICT_ENA, iPREV_PREDICT_HIT;
  logic        iPREV_PREDICT_MISS_VALID, iPREV_ADDR_MISS_VALID, iPREV_IB_VALID;
  logic [2:0]  iPREV_SYSREG_VALID;
  logic        iNEXT_BUSY;

  logic        oPREV_BUSY, oNEXT_VALID, oNEXT_PREDICT_ENA, oNEXT_PREDICT_HIT;
  logic        oNEXT_JUMP_VALID, oNEXT_TYPE_BRANCH_VALID, oNEXT_TYPE_BRANCH_IB_VALID;
  logic [31:0] oNEXT_JUMP_ADDR;
  logic [2:0]  oNEXT_TYPE_SYSREG_VALID;
  logic        oSQUASH;
  logic [2:0]  oCOUNT;

  logic        ns_prev_busy, ns_valid, ns_pe, ns_ph, ns_jump, ns_tb, ns_ib;
  logic [31:0] ns_addr;
  logic [2:0]  ns_sv;
  logic        ns_squash;
  logic [2:0]  ns_count;

  always #5 iCLOCK = ~iCLOCK;

  execute_jump_queue u_dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iEVENT_HOLD(iEVENT_HOLD), .iEVENT_END(iEVENT_END), .iSTATE_NORMAL(iSTATE_NORMAL),
    .iPREV_VALID(iPREV_VALID), .iPREV_EX_BRANCH(iPREV_EX_BRANCH),
    .iPREV_EX_SYS_REG(iPREV_EX_SYS_REG), .iPREV_PC(iPREV_PC),
    .iPREV_PREDICT_ENA(iPREV_PREDICT_ENA), .iPREV_PREDICT_HIT(iPREV_PREDICT_HIT),
    .iPREV_PREDICT_MISS_VALID(iPREV_PREDICT_MISS_VALID),
    .iPREV_ADDR_MISS_VALID(iPREV_ADDR_MISS_VALID), .iPREV_IB_VALID(iPREV_IB_VALID),
    .iPREV_BRANCH_ADDR(iPREV_BRANCH_ADDR), .iPREV_SYSREG_VALID(iPREV_SYSREG_VALID),
    .iPREV_SYSREG_ADDR(iPREV_SYSREG_ADDR), .oPREV_BUSY(oPREV_BUSY),
    .iNEXT_BUSY(iNEXT_BUSY), .oNEXT_VALID(oNEXT_VALID),
    .oNEXT_PREDICT_ENA(oNEXT_PREDICT_ENA), .oNEXT_PREDICT_HIT(oNEXT_PREDICT_HIT),
    .oNEXT_JUMP_VALID(oNEXT_JUMP_VALID), .oNEXT_JUMP_ADDR(oNEXT_JUMP_ADDR),
    .oNEXT_TYPE_BRANCH_VALID(oNEXT_TYPE_BRANCH_VALID),
    .oNEXT_TYPE_BRANCH_IB_VALID(oNEXT_TYPE_BRANCH_IB_VALID),
    .oNEXT_TYPE_SYSREG_VALID(oNEXT_TYPE_SYSREG_VALID), .oSQUASH(oSQUASH),
    .oCOUNT(oCOUNT)
  );

  execute_jump_queue #(.P_SQUASH(0)) u_dut_ns (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iEVENT_HOLD(iEVENT_HOLD), .iEVENT_END(iEVENT_END), .iSTATE_NORMAL(iSTATE_NORMAL),
    .iPREV_VALID(iPREV_VALID), .iPREV_EX_BRANCH(iPREV_EX_BRANCH),
    .iPREV_EX_SYS_REG(iPREV_EX_SYS_REG), .iPREV_PC(iPREV_PC),
    .iPREV_PREDICT_ENA(iPREV_PREDICT_ENA), .iPREV_PREDICT_HIT(iPREV_PREDICT_HIT),
    .iPREV_PREDICT_MISS_VALID(iPREV_PREDICT_MISS_VALID),
    .iPREV_ADDR_MISS_VALID(iPREV_ADDR_MISS_VALID), .iPREV_IB_VALID(iPREV_IB_VALID),
    .iPREV_BRANCH_ADDR(iPREV_BRANCH_ADDR), .iPREV_SYSREG_VALID(iPREV_SYSREG_VALID),
    .iPREV_SYSREG_ADDR(iPREV_SYSREG_ADDR), .oPREV_BUSY(ns_prev_busy),
    .iNEXT_BUSY(iNEXT_BUSY), .oNEXT_VALID(ns_valid),
    .oNEXT_PREDICT_ENA(ns_pe), .oNEXT_PREDICT_HIT(ns_ph),
    .oNEXT_JUMP_VALID(ns_jump), .oNEXT_JUMP_ADDR(ns_addr),
    .oNEXT_TYPE_BRANCH_VALID(ns_tb), .oNEXT_TYPE_BRANCH_IB_VALID(ns_ib),
    .oNEXT_TYPE_SYSREG_VALID(ns_sv), .oSQUASH(ns_squash), .oCOUNT(ns_count)
  );

  typedef struct {
    logic        normal, valid, br, sr;
    logic [4:0]  f;      // {miss, addr_miss, ib, predict_ena, predict_hit}
    logic [2:0]  sv;
    logic [31:0] pc, baddr, saddr;
    logic        nbusy;
    logic [2:0]  clr;    // {reset_sync, event_hold, event_end}
  } stim_t;

  typedef struct packed {
    logic        valid, jump, tb, ib, pe, ph;
    logic [2:0]  sv;
    logic [31:0] addr;
    logic        squash;
    logic [2:0]  count;
    logic        pbusy;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  function automatic stim_t st(input logic normal, valid, br, sr, input logic [4:0] f,
                               input logic [2:0] sv, input logic [31:0] pc, baddr, saddr,
                               input logic nbusy, input logic [2:0] clr);
    stim_t s;
    s.normal = normal; s.valid = valid; s.br = br; s.sr = sr; s.f = f; s.sv = sv;
    s.pc = pc; s.baddr = baddr; s.saddr = saddr; s.nbusy = nbusy; s.clr = clr;
    return s;
  endfunction

  function automatic exp_t ex(input logic valid, jump, tb, ib, pe, ph, input logic [2:0] sv,
                              input logic [31:0] addr, input logic squash,
                              input logic [2:0] count, input logic pbusy);
    exp_t e;
    e.valid = valid; e.jump = jump; e.tb = tb; e.ib = ib; e.pe = pe; e.ph = ph;
    e.sv = sv; e.addr = addr; e.squash = squash; e.count = count; e.pbusy = pbusy;
    return e;
  endfunction

  function automatic exp_t got();
    return ex(oNEXT_VALID, oNEXT_JUMP_VALID, oNEXT_TYPE_BRANCH_VALID,
              oNEXT_TYPE_BRANCH_IB_VALID, oNEXT_PREDICT_ENA, oNEXT_PREDICT_HIT,
              oNEXT_TYPE_SYSREG_VALID, oNEXT_JUMP_ADDR, oSQUASH, oCOUNT, oPREV_BUSY);
  endfunction

  function automatic exp_t got_ns();
    return ex(ns_valid, ns_jump, ns_tb, ns_ib, ns_pe, ns_ph, ns_sv, ns_addr,
              ns_squash, ns_count, ns_prev_busy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input stim_t s);
    iSTATE_NORMAL            = s.normal;
    iPREV_VALID              = s.valid;
    iPREV_EX_BRANCH          = s.br;
    iPREV_EX_SYS_REG         = s.sr;
    iPREV_PREDICT_MISS_VALID = s.f[4];
    iPREV_ADDR_MISS_VALID    = s.f[3];
    iPREV_IB_VALID           = s.f[2];
    iPREV_PREDICT_ENA        = s.f[1];
    iPREV_PREDICT_HIT        = s.f[0];
    iPREV_SYSREG_VALID       = s.sv;
    iPREV_PC                 = s.pc;
    iPREV_BRANCH_ADDR        = s.baddr;
    iPREV_SYSREG_ADDR        = s.saddr;
    iNEXT_BUSY               = s.nbusy;
    iRESET_SYNC              = s.clr[2];
    iEVENT_HOLD              = s.clr[1];
    iEVENT_END               = s.clr[0];
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  function automatic stim_t plain_br(input logic [1:0] pp, input logic nbusy);
    return st(1, 1, 1, 0, {3'b000, pp}, 3'b0, 32'h80, 32'h90, 32'h0, nbusy, 3'b0);
  endfunction

  initial begin
    exp_t z;
    z = '0;

    // Vector table: inputs held for one edge, outputs checked just after it.
    vecs.push_back('{st(1,0,0,0,5'b00000,3'b000,32'h0,32'h0,32'h0,0,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,1,0,5'b10010,3'b000,32'h100,32'hdead,32'h0,0,3'b000), ex(1,1,1,0,1,0,3'b000,32'h100,1,1,0)});
    vecs.push_back('{st(1,0,0,0,5'b00000,3'b000,32'h0,32'h0,32'h0,0,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,0,1,5'b00011,3'b010,32'h55,32'h77,32'h40,1,3'b000), ex(1,0,0,0,0,0,3'b010,32'h40,1,1,0)});
    vecs.push_back('{st(1,1,1,0,5'b00011,3'b000,32'h60,32'h0,32'h0,1,3'b000), ex(1,0,0,0,0,0,3'b010,32'h40,1,1,0)});
    vecs.push_back('{st(1,0,0,0,5'b00000,3'b000,32'h0,32'h0,32'h0,0,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,1,0,5'b00111,3'b000,32'h10,32'h3000,32'h0,1,3'b000), ex(1,0,0,1,1,1,3'b000,32'h3000,1,1,0)});
    vecs.push_back('{st(1,0,0,0,5'b00000,3'b000,32'h0,32'h0,32'h0,1,3'b001), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(0,1,1,0,5'b10000,3'b000,32'h200,32'h0,32'h0,1,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,1,0,5'b11010,3'b000,32'h300,32'h400,32'h0,1,3'b000), ex(1,1,1,0,1,0,3'b000,32'h400,1,1,0)});
    vecs.push_back('{st(0,0,0,0,5'b00000,3'b000,32'h0,32'h0,32'h0,0,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,0,0,5'b10011,3'b111,32'h1,32'h2,32'h3,1,3'b000), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,1,0,5'b00011,3'b000,32'h500,32'h600,32'h0,1,3'b000), ex(1,0,0,0,1,1,3'b000,32'h0,0,1,0)});
    vecs.push_back('{st(1,1,1,0,5'b00000,3'b000,32'h510,32'h610,32'h0,1,3'b000), ex(1,0,0,0,1,1,3'b000,32'h0,0,2,0)});
    vecs.push_back('{st(1,1,1,0,5'b00010,3'b000,32'h520,32'h0,32'h0,0,3'b000), ex(1,0,0,0,0,0,3'b000,32'h0,0,2,0)});
    vecs.push_back('{st(1,1,1,0,5'b10000,3'b000,32'h700,32'h0,32'h0,0,3'b010), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});
    vecs.push_back('{st(1,1,1,0,5'b00000,3'b000,32'h0,32'h0,32'h0,1,3'b000), ex(1,0,0,0,0,0,3'b000,32'h0,0,1,0)});
    vecs.push_back('{st(1,1,1,0,5'b10000,3'b000,32'h800,32'h0,32'h0,0,3'b100), ex(0,0,0,0,0,0,3'b000,32'h0,0,0,0)});

    // Reset state.
    inRESET = 1'b0;
    drive(st(0,0,0,0,5'b0,3'b0,32'h0,32'h0,32'h0,0,3'b0));
    #12;
    check("reset_outputs", 64'(got()), 64'(z));
    check("reset_outputs_ns", 64'(got_ns()), 64'(z));
    inRESET = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].s);
      tick();
      check($sformatf("vec%0d", i), 64'(got()), 64'(vecs[i].e));
    end

    // Fill to capacity with non-redirect branches while downstream stalls.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pp;
      pp = i[1:0];
      drive(plain_br(pp, 1'b1));
      tick();
      check($sformatf("fill_count%0d", i), 64'(oCOUNT), 64'(i + 1));
    end
    check("full_busy", 64'(oPREV_BUSY), 64'd1);
    check("full_busy_ns", 64'({ns_prev_busy, ns_count}), 64'({1'b1, 3'd4}));
    drive(plain_br(2'b00, 1'b1));
    tick();
    check("fifth_dropped", 64'({oPREV_BUSY, oCOUNT}), 64'({1'b1, 3'd4}));
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pp;
      pp = i[1:0];
      check($sformatf("drain_head%0d", i), 64'({oNEXT_VALID, oNEXT_PREDICT_ENA, oNEXT_PREDICT_HIT}),
            64'({1'b1, pp}));
      drive(st(1,0,0,0,5'b0,3'b0,32'h0,32'h0,32'h0,0,3'b0));
      tick();
    end
    check("drained", 64'({oNEXT_VALID, oCOUNT}), 64'd0);

    // Redirect then wrong-path branches while stalled: all discarded.
    drive(st(1,1,1,0,5'b01000,3'b0,32'h1ff,32'h2000,32'h0,1,3'b0));
    tick();
    check("sq_enter", 64'({oSQUASH, oNEXT_JUMP_VALID, oCOUNT, oNEXT_JUMP_ADDR}),
          64'({1'b1, 1'b1, 3'd1, 32'h2000}));
    check("ns_no_squash", 64'({ns_squash, ns_count}), 64'({1'b0, 3'd1}));
    for (int k = 0; k < 3; k++) begin
      drive(plain_br(2'b01, 1'b1));
      tick();
      check($sformatf("sq_discard%0d", k), 64'({oPREV_BUSY, oCOUNT}), 64'({1'b0, 3'd1}));
    end
    check("ns_accepts", 64'({ns_squash, ns_prev_busy, ns_count}), 64'({1'b0, 1'b1, 3'd4}));
    drive(st(1,0,0,0,5'b0,3'b0,32'h0,32'h0,32'h0,0,3'b0));
    tick();
    check("sq_exit", 64'({oSQUASH, oCOUNT}), 64'({1'b0, 3'd0}));
    check("ns_pop", 64'(ns_count), 64'd3);
    drive(plain_br(2'b11, 1'b1));
    tick();
    check("after_sq_accept", 64'({oNEXT_VALID, oCOUNT, oNEXT_PREDICT_ENA}), 64'({1'b1, 3'd1, 1'b1}));
    drive(st(1,0,0,0,5'b0,3'b0,32'h0,32'h0,32'h0,1,3'b100));
    tick();
    check("sync_clear_ns", 64'(got_ns()), 64'(z));

    // Asynchronous reset in the middle of a cycle with a redirect queued.
    drive(st(1,1,1,0,5'b10000,3'b0,32'h900,32'h0,32'h0,1,3'b0));
    tick();
    check("pre_async", 64'({oSQUASH, oCOUNT, oNEXT_JUMP_ADDR}), 64'({1'b1, 3'd1, 32'h900}));
    #3;
    inRESET = 1'b0;
    #1;
    check("async_reset", 64'(got()), 64'(z));
    #2;
    inRESET = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
